// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// opcode encodings and the fetch FSM state type.
package instruction_fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_HALT = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch FSM: request -> capture -> hold; valid 2 cycles after mem_req, 3 cycles/instr minimum.
// Holds the instruction stable while input_instr_ready=0; PC pulses only on the accepting cycle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               input_clk,
  input  logic               input_reset,
  input  logic [ADDR_W-1:0]  input_pc,
  output logic               output_pc_enable,
  output logic               output_pc_load,
  output logic [ADDR_W-1:0]  output_pc_load_value,
  output logic               output_mem_req,
  output logic [ADDR_W-1:0]  output_mem_addr,
  input  logic [INSTR_W-1:0] input_mem_data,
  output logic [INSTR_W-1:0] output_instr,
  output logic [ADDR_W-1:0]  output_instr_pc,
  output logic               output_instr_valid,
  input  logic               input_instr_ready
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [3:0]         opcode;
  logic               handshake;

  assign opcode    = instr_q[INSTR_W-1 -: 4];
  // Gated by reset so an accept coinciding with reset never moves the PC.
  assign handshake = (state_q == ST_HOLD) && input_instr_ready && !input_reset;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      ST_IDLE:    state_d = ST_ISSUE;
      ST_ISSUE: begin
        instr_pc_d = input_pc;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        instr_d = input_mem_data;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (input_instr_ready) begin
          state_d = (opcode == OP_HALT) ? ST_HALTED : ST_ISSUE;
        end
      end
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // The address follows input_pc live so a PC updated on the accepting edge is fetched next.
  assign output_mem_req       = (state_q == ST_ISSUE);
  assign output_mem_addr      = output_mem_req ? input_pc : '0;
  assign output_instr_valid   = (state_q == ST_HOLD);
  assign output_instr         = instr_q;
  assign output_instr_pc      = instr_pc_q;
  assign output_pc_load       = handshake && (opcode == OP_JMP);
  assign output_pc_enable     = handshake && (opcode != OP_JMP) && (opcode != OP_HALT);
  assign output_pc_load_value = output_pc_load ? instr_q[ADDR_W-1:0] : '0;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning PC/address width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 The block SHALL have port input_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port input_reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port input_pc  in  ADDR_W  current value from the program counter.
REQ-006 The block SHALL have port output_pc_enable  out  1  single-cycle advance pulse to the program counter.
REQ-007 The block SHALL have port output_pc_load  out  1  single-cycle jump-load pulse to the program counter.
REQ-008 The block SHALL have port output_pc_load_value  out  ADDR_W  jump target, valid while output_pc_load=1.
REQ-009 The block SHALL have port output_mem_req  out  1  instruction-memory read strobe.
REQ-010 The block SHALL have port output_mem_addr  out  ADDR_W  read address.
REQ-011 The block SHALL have port input_mem_data  in  INSTR_W  read data, valid exactly one cycle after output_mem_req.
REQ-012 The block SHALL have ports output_instr (out, INSTR_W), output_instr_pc (out, ADDR_W) and output_instr_valid (out, 1) as the downstream instruction stream.
REQ-013 The block SHALL have port input_instr_ready  in  1  downstream accept.

Function
REQ-014 The instruction format SHALL be opcode=[15:12] and target=[7:0]; opcode 4'hF = JMP, 4'hE = HALT, all others = sequential.
REQ-015 The FSM SHALL have states IDLE, ISSUE, CAPTURE, HOLD and HALTED.
REQ-016 IDLE SHALL last exactly one cycle after reset, then go to ISSUE.
REQ-017 ISSUE SHALL assert output_mem_req=1 and output_mem_addr=input_pc, register input_pc as the instruction PC, and go to CAPTURE.
REQ-018 CAPTURE SHALL register input_mem_data into output_instr and go to HOLD.
REQ-019 In HOLD, output_instr_valid SHALL be 1, and output_instr and output_instr_pc SHALL stay stable until input_instr_ready=1.
REQ-020 A handshake (HOLD, valid=1, ready=1) on a sequential opcode SHALL pulse output_pc_enable for that cycle and go to ISSUE.
REQ-021 A handshake on JMP SHALL pulse output_pc_load with output_pc_load_value=instr[7:0], keep output_pc_enable=0, and go to ISSUE.
REQ-022 A handshake on HALT SHALL assert neither PC pulse and SHALL go to HALTED; HALTED issues no requests until reset.
REQ-023 output_pc_enable and output_pc_load SHALL never be 1 in the same cycle, and each SHALL be 1 for at most one cycle per instruction.
REQ-024 Latency SHALL be 2 cycles from output_mem_req to output_instr_valid, giving a 3-cycle minimum per instruction.
REQ-025 PC wrap SHALL need no special handling: advancing from 8'hFF fetches 8'h00 next.
REQ-026 A JMP whose target equals its own PC SHALL be legal and SHALL refetch the same address.
REQ-027 output_mem_req SHALL be 0 in every state except ISSUE.
REQ-028 output_pc_load_value SHALL be 0 whenever output_pc_load=0.

Reset
REQ-029 On input_reset=1 at a clock edge, the FSM SHALL go to IDLE, and output_instr_valid, output_mem_req, output_pc_enable and output_pc_load SHALL be 0.
REQ-030 On reset, output_instr, output_instr_pc, output_mem_addr and output_pc_load_value SHALL be 0.
REQ-031 Reset asserted mid-operation (any state) SHALL discard in-flight memory data, and no PC pulse SHALL occur in the reset cycle.
REQ-032 Reset SHALL be the only exit from HALTED.

Structure
REQ-033 A shared package SHALL hold the opcode constants (JMP=4'hF, HALT=4'hE), the FSM state encoding, and the ADDR_W/INSTR_W defaults.
REQ-034 The block SHALL be a single module with no sub-module; the program counter and memory stay external.

Verification
REQ-035 Scenario: reset, then a ROM of sequential words at 8'h00..8'h03 with ready=1 -> valid every 3rd cycle; instr_pc sequence 00,01,02,03; one enable pulse each.
REQ-036 Scenario: word 16'hF042 at 8'h01 -> load pulse with value 8'h42, no enable pulse; next instr_pc=8'h42.
REQ-037 Scenario: ready held 0 for 5 cycles in HOLD -> valid, instr and instr_pc stable; no PC pulse; no mem_req until ready.
REQ-038 Scenario: HALT word 16'hE000 at 8'h02 -> delivered once, then mem_req=0 for 20 cycles; reset -> fetch restarts at 8'h00.
REQ-039 Scenario: reset asserted in CAPTURE -> valid=0 next cycle, no PC pulse; first post-reset fetch uses the current input_pc.
REQ-040 Scenario: PC at 8'hFF with a sequential word -> enable pulse; next fetch address 8'h00.
